// File: rtl/next_tx_scheduler_if.sv
// next_tx_scheduler_if: event inputs and the 40-bit word channel of the
// NeXT monitor-link packet scheduler.
//
// Word channel handshake: tx_valid says tx_data holds a word; tx_data is held
// stable while tx_valid=1; the word transfers on a rising mon_clk edge where
// tx_valid and tx_ready are both 1; tx_valid never depends combinationally on
// tx_ready.
interface next_tx_scheduler_if;
   logic        power_on_req;
   logic        kb_valid;
   logic        kb_is_mouse;
   logic [15:0] kb_data;
   logic        tx_ready;
   logic        tx_valid;
   logic [39:0] tx_data;

   // scheduler side
   modport master (
      input  power_on_req,
      input  kb_valid,
      input  kb_is_mouse,
      input  kb_data,
      input  tx_ready,
      output tx_valid,
      output tx_data
   );

   // event sources and serial sender side
   modport slave (
      output power_on_req,
      output kb_valid,
      output kb_is_mouse,
      output kb_data,
      output tx_ready,
      input  tx_valid,
      input  tx_data
   );
endinterface

// File: rtl/next_tx_scheduler.sv
// next_tx_scheduler: schedules non-audio packets to the NeXT host.
// Keyboard/mouse events are buffered in a small FIFO, a pending power-on
// reply always wins arbitration, and every accepted word is followed by a
// GAP_CYCLES idle gap before the next one may be presented.
// Optional feature macro: NEXT_TX_DROP_COUNT_EN (saturating drop counter);
// without it drop_count reads 8'h00 and full-FIFO drops are silent.
module next_tx_scheduler #(
   parameter int          FIFO_DEPTH    = 4,
   parameter int          GAP_CYCLES    = 8,
   parameter logic [39:0] POWER_ON_WORD = 40'hC0_0000_0000,
   parameter logic [7:0]  KEY_PREFIX    = 8'hC5,
   parameter logic [7:0]  MOUSE_PREFIX  = 8'hC6,
   localparam int         AW            = $clog2(FIFO_DEPTH),
   localparam int         LW            = AW + 1
) (
   input  logic                      mon_clk,
   input  logic                      reset,
   next_tx_scheduler_if.master       bus,
   output logic [LW-1:0]             fifo_level,
   output logic [7:0]                drop_count,
   output logic                      busy,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [7:0]    GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   state_t        state, state_nx;
   logic [7:0]    gap_cnt, gap_cnt_nx;
   logic [39:0]   tx_data_q, tx_data_nx;
   logic          sending_po, sending_po_nx;
   logic          po_pending;

   // event FIFO: 17-bit entries {is_mouse, payload}
   logic [16:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [LW-1:0] level;
   logic          fifo_full, fifo_empty;
   logic          handshake, pop, push;
   logic [16:0]   head;

   assign fifo_full  = (level == FULL_LVL);
   assign fifo_empty = (level == '0);
   assign head       = mem[rd_ptr];
   assign handshake  = (state == S_SEND) && bus.tx_ready;
   // the word in flight came from the FIFO head only when it is not the power-on reply
   assign pop        = handshake && !sending_po;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push       = bus.kb_valid && (!fifo_full || pop);

   // FIFO storage write; contents are discarded on reset by resetting the pointers
   always_ff @(posedge mon_clk) begin
      if (push) mem[wr_ptr] <= {bus.kb_is_mouse, bus.kb_data};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge mon_clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // power-on request flag; a new request wins over the clear so the reply repeats
   always_ff @(posedge mon_clk or posedge reset) begin
      if (reset) begin
         po_pending <= 1'b0;
      end else if (bus.power_on_req) begin
         po_pending <= 1'b1;
      end else if (handshake && sending_po) begin
         po_pending <= 1'b0;
      end
   end

   // FSM state, gap counter and presented word registers
   always_ff @(posedge mon_clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         gap_cnt    <= 8'd0;
         tx_data_q  <= 40'd0;
         sending_po <= 1'b0;
      end else begin
         state      <= state_nx;
         gap_cnt    <= gap_cnt_nx;
         tx_data_q  <= tx_data_nx;
         sending_po <= sending_po_nx;
      end
   end

   // next-state: arbitrate in IDLE, hold the word in SEND, count down in GAP
   always_comb begin
      state_nx      = state;
      gap_cnt_nx    = gap_cnt;
      tx_data_nx    = tx_data_q;
      sending_po_nx = sending_po;
      case (state)
         S_IDLE: begin
            if (po_pending) begin
               tx_data_nx    = POWER_ON_WORD;
               sending_po_nx = 1'b1;
               state_nx      = S_SEND;
            end else if (!fifo_empty) begin
               tx_data_nx    = {(head[16] ? MOUSE_PREFIX : KEY_PREFIX), head[15:0], 16'h0000};
               sending_po_nx = 1'b0;
               state_nx      = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.tx_ready) begin
               if (GAP_CYCLES == 0) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx   = S_GAP;
                  gap_cnt_nx = GAP_LOAD;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == 8'd0) begin
               state_nx = S_IDLE;
            end else begin
               gap_cnt_nx = gap_cnt - 8'd1;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

`ifdef NEXT_TX_DROP_COUNT_EN
   logic       drop;
   logic [7:0] drop_cnt;

   assign drop = bus.kb_valid && fifo_full && !pop;

   // saturating count of events lost on a full FIFO
   always_ff @(posedge mon_clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= 8'd0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign drop_count = drop_cnt;
`else
   assign drop_count = 8'h00;
`endif

   // tx_valid comes straight from the state register so reset clears it at once
   assign bus.tx_valid = (state == S_SEND);
   assign bus.tx_data  = tx_data_q;
   assign fifo_level   = level;
   assign busy         = (state != S_IDLE) || po_pending || !fifo_empty;
   assign state_dbg    = state;

endmodule

// File: tb/tb_next_tx_scheduler.sv
// tb_next_tx_scheduler: directed and random stimulus for next_tx_scheduler,
// checked every cycle against a queue-based packet model, plus literal
// expectations for the named scenarios.
module tb_next_tx_scheduler;
   localparam int FIFO_DEPTH = 4;
   localparam int GAP_CYCLES = 8;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef NEXT_TX_DROP_COUNT_EN
   localparam logic [7:0] EXP_DROP2 = 8'd2;
   localparam logic [7:0] EXP_SAT   = 8'd255;
`else
   localparam logic [7:0] EXP_DROP2 = 8'd0;
   localparam logic [7:0] EXP_SAT   = 8'd0;
`endif

   // clock / reset
   logic mon_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 mon_clk = ~mon_clk;

   next_tx_scheduler_if bus_if();
   logic [LW-1:0] fifo_level;
   logic [7:0]    drop_count;
   logic          busy;
   logic [1:0]    state_dbg;

   next_tx_scheduler #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .mon_clk    (mon_clk),
      .reset      (reset),
      .bus        (bus_if.master),
      .fifo_level (fifo_level),
      .drop_count (drop_count),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   int vectors     = 0;
   int miscompares = 0;
   int dut_hs      = 0;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // scoreboard of queued events, pending power-on flag, word being offered,
   // and the earliest edge at which the next word may be loaded
   logic [16:0] exp_q[$];
   bit          m_po        = 1'b0;
   bit          m_valid     = 1'b0;
   bit          m_is_po     = 1'b0;
   logic [39:0] m_word      = 40'd0;
   int          m_drop      = 0;
   int          m_edge      = 0;
   int          m_next_load = 0;

   function automatic logic [39:0] pkt(input logic [16:0] ev);
      return {(ev[16] ? 8'hC6 : 8'hC5), ev[15:0], 16'h0000};
   endfunction

   task automatic model_step();
      bit hs, pop, full;
      if (reset) begin
         exp_q.delete();
         m_po = 0; m_valid = 0; m_is_po = 0; m_word = 40'd0;
         m_drop = 0; m_edge = 0; m_next_load = 0;
         return;
      end
      m_edge++;
      hs   = m_valid && bus_if.tx_ready;
      full = (exp_q.size() == FIFO_DEPTH);
      pop  = hs && !m_is_po;
      if (!m_valid && m_edge >= m_next_load && (m_po || exp_q.size() != 0)) begin
         m_valid = 1;
         m_is_po = m_po;
         m_word  = m_po ? 40'hC0_0000_0000 : pkt(exp_q[0]);
      end
      if (hs) begin
         m_valid     = 0;
         m_next_load = m_edge + GAP_CYCLES + 1;
         if (pop) void'(exp_q.pop_front());
      end
      if (bus_if.kb_valid) begin
         if (!full || pop) exp_q.push_back({bus_if.kb_is_mouse, bus_if.kb_data});
         else begin
`ifdef NEXT_TX_DROP_COUNT_EN
            if (m_drop < 255) m_drop++;
`endif
         end
      end
      if (bus_if.power_on_req) m_po = 1;
      else if (hs && m_is_po)  m_po = 0;
   endtask

   always @(posedge mon_clk or posedge reset) model_step();

   always @(posedge mon_clk) if (!reset && bus_if.tx_valid && bus_if.tx_ready) dut_hs++;

   // compare process: every cycle, away from the active edge
   always @(negedge mon_clk) begin
      chk("tx_valid",   {39'd0, bus_if.tx_valid}, {39'd0, m_valid});
      chk("tx_data",    bus_if.tx_data, m_word);
      chk("fifo_level", {{(40-LW){1'b0}}, fifo_level}, 40'(exp_q.size()));
      chk("drop_count", {32'd0, drop_count}, 40'(m_drop));
      chk("busy",       {39'd0, busy},
          {39'd0, (m_valid || (m_edge + 1 < m_next_load) || m_po || exp_q.size() != 0)});
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_kb(input logic mouse, input logic [15:0] data);
      @(negedge mon_clk);
      bus_if.kb_valid = 1; bus_if.kb_is_mouse = mouse; bus_if.kb_data = data;
      @(negedge mon_clk);
      bus_if.kb_valid = 0;
   endtask

   task automatic pulse_po();
      @(negedge mon_clk);
      bus_if.power_on_req = 1;
      @(negedge mon_clk);
      bus_if.power_on_req = 0;
   endtask

   task automatic wait_valid(input logic lvl, input int budget, input string name);
      int n = 0;
      while (bus_if.tx_valid !== lvl && n < budget) begin
         @(negedge mon_clk);
         n++;
      end
      chk(name, {39'd0, bus_if.tx_valid}, {39'd0, lvl});
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((busy !== 1'b0 || bus_if.tx_valid !== 1'b0) && n < budget) begin
         @(negedge mon_clk);
         n++;
      end
      chk(name, {39'd0, busy}, 40'd0);
   endtask

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int base;
      bus_if.power_on_req = 0; bus_if.kb_valid = 0; bus_if.kb_is_mouse = 0;
      bus_if.kb_data = 16'h0; bus_if.tx_ready = 0;
      repeat (3) @(negedge mon_clk);
      chk("rst_tx_valid",   {39'd0, bus_if.tx_valid}, 40'd0);
      chk("rst_tx_data",    bus_if.tx_data, 40'd0);
      chk("rst_fifo_level", {{(40-LW){1'b0}}, fifo_level}, 40'd0);
      chk("rst_drop_count", {32'd0, drop_count}, 40'd0);
      chk("rst_busy",       {39'd0, busy}, 40'd0);
      reset = 0;

      // single key: valid two edges after the sampling edge, then the gap
      bus_if.tx_ready = 1;
      pulse_kb(1'b0, 16'h1234);
      chk("key_not_yet", {39'd0, bus_if.tx_valid}, 40'd0);
      @(negedge mon_clk);
      chk("key_valid", {39'd0, bus_if.tx_valid}, 40'd1);
      chk("key_data",  bus_if.tx_data, 40'hC5_1234_0000);
      for (int i = 0; i < 8; i++) begin
         @(negedge mon_clk);
         chk("key_gap_low", {39'd0, bus_if.tx_valid}, 40'd0);
      end
      wait_idle(50, "key_idle");

      // priority: power-on beats a key sampled on the same edge
      @(negedge mon_clk);
      bus_if.kb_valid = 1; bus_if.kb_is_mouse = 0; bus_if.kb_data = 16'h00AA;
      bus_if.power_on_req = 1;
      @(negedge mon_clk);
      bus_if.kb_valid = 0; bus_if.power_on_req = 0;
      wait_valid(1'b1, 10, "prio_first_valid");
      chk("prio_first_data", bus_if.tx_data, 40'hC0_0000_0000);
      wait_valid(1'b0, 5, "prio_first_done");
      wait_valid(1'b1, 30, "prio_second_valid");
      chk("prio_second_data", bus_if.tx_data, 40'hC5_00AA_0000);
      wait_idle(50, "prio_idle");

      // backpressure: word held for 20 cycles, accepted on first ready
      bus_if.tx_ready = 0;
      pulse_kb(1'b1, 16'hBEEF);
      wait_valid(1'b1, 10, "bp_valid");
      for (int i = 0; i < 20; i++) begin
         chk("bp_hold_valid", {39'd0, bus_if.tx_valid}, 40'd1);
         chk("bp_hold_data",  bus_if.tx_data, 40'hC6_BEEF_0000);
         @(negedge mon_clk);
      end
      bus_if.tx_ready = 1;
      @(negedge mon_clk);
      chk("bp_accepted", {39'd0, bus_if.tx_valid}, 40'd0);
      wait_idle(50, "bp_idle");

      // overflow: 6 events into a 4-deep FIFO with the sender stalled
      bus_if.tx_ready = 0;
      @(negedge mon_clk);
      for (int i = 0; i < 6; i++) begin
         bus_if.kb_valid = 1; bus_if.kb_is_mouse = 0; bus_if.kb_data = 16'h0100 + 16'(i);
         @(negedge mon_clk);
      end
      bus_if.kb_valid = 0;
      chk("ovf_level", {{(40-LW){1'b0}}, fifo_level}, 40'd4);
      chk("ovf_drops", {32'd0, drop_count}, {32'd0, EXP_DROP2});
      bus_if.tx_ready = 1;
      for (int i = 0; i < 4; i++) begin
         wait_valid(1'b1, 30, "ovf_word_valid");
         chk("ovf_word_data", bus_if.tx_data, {8'hC5, 16'h0100 + 16'(i), 16'h0000});
         wait_valid(1'b0, 5, "ovf_word_done");
      end
      wait_idle(50, "ovf_idle");

      // coalescing: three power-on pulses during a key SEND give one reply
      bus_if.tx_ready = 0;
      pulse_kb(1'b0, 16'h0055);
      wait_valid(1'b1, 10, "coal_valid");
      base = dut_hs;
      repeat (3) pulse_po();
      bus_if.tx_ready = 1;
      wait_valid(1'b0, 5, "coal_key_done");
      wait_valid(1'b1, 30, "coal_po_valid");
      chk("coal_po_data", bus_if.tx_data, 40'hC0_0000_0000);
      wait_idle(60, "coal_idle");
      chk("coal_count", 40'(dut_hs - base), 40'd2);

      // request on the clearing handshake edge: reply sent twice
      bus_if.tx_ready = 0;
      pulse_po();
      wait_valid(1'b1, 10, "rep_valid");
      base = dut_hs;
      @(negedge mon_clk);
      bus_if.tx_ready = 1; bus_if.power_on_req = 1;
      @(negedge mon_clk);
      bus_if.power_on_req = 0;
      wait_valid(1'b1, 30, "rep_second_valid");
      chk("rep_second_data", bus_if.tx_data, 40'hC0_0000_0000);
      wait_idle(60, "rep_idle");
      chk("rep_count", 40'(dut_hs - base), 40'd2);

      // saturation: 4 accepted then 300 drops
      bus_if.tx_ready = 0;
      @(negedge mon_clk);
      for (int i = 0; i < 304; i++) begin
         bus_if.kb_valid = 1; bus_if.kb_is_mouse = 1'($urandom_range(0, 1));
         bus_if.kb_data = 16'($urandom_range(0, 65535));
         @(negedge mon_clk);
      end
      bus_if.kb_valid = 0;
      chk("sat_drops", {32'd0, drop_count}, {32'd0, EXP_SAT});
      bus_if.tx_ready = 1;
      wait_idle(200, "sat_idle");

      // random traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge mon_clk);
         bus_if.kb_valid     = ($urandom_range(0, 3) == 0);
         bus_if.kb_is_mouse  = 1'($urandom_range(0, 1));
         bus_if.kb_data      = 16'($urandom_range(0, 65535));
         bus_if.power_on_req = ($urandom_range(0, 19) == 0);
         bus_if.tx_ready     = ($urandom_range(0, 3) != 0);
      end
      @(negedge mon_clk);
      bus_if.kb_valid = 0; bus_if.power_on_req = 0; bus_if.tx_ready = 1;
      wait_idle(400, "rand_idle");

      // reset mid-SEND
      bus_if.tx_ready = 0;
      pulse_kb(1'b0, 16'h7777);
      pulse_kb(1'b1, 16'h8888);
      wait_valid(1'b1, 10, "rst_mid_valid");
      #2 reset = 1;
      #1;
      chk("rst_mid_tx_valid",   {39'd0, bus_if.tx_valid}, 40'd0);
      chk("rst_mid_fifo_level", {{(40-LW){1'b0}}, fifo_level}, 40'd0);
      @(negedge mon_clk);
      reset = 0;
      bus_if.tx_ready = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge mon_clk);
         chk("post_rst_quiet", {39'd0, bus_if.tx_valid}, 40'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
